// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues one icache request per cycle, buffers {instr, pc} in a 2-entry FIFO.
// Redirect to first instr_valid is 3 cycles on hits; requests stall when the buffer plus the in-flight slot is full.
module fetch_unit #(
  parameter int                      DATABITWIDTH = 16,
  parameter int                      ADDRESSWIDTH = 10,
  parameter logic [ADDRESSWIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                    clk,
  input  logic                    sync_rst,
  input  logic                    clk_en,
  output logic                    icache_req,
  output logic [ADDRESSWIDTH-1:0] icache_addr,
  input  logic [DATABITWIDTH-1:0] icache_data,
  input  logic                    icache_busy,
  input  logic                    redirect_valid,
  input  logic [ADDRESSWIDTH-1:0] redirect_addr,
  output logic                    instr_valid,
  output logic [DATABITWIDTH-1:0] instr,
  output logic [ADDRESSWIDTH-1:0] instr_pc,
  input  logic                    instr_ready
);

  typedef struct packed {
    logic [DATABITWIDTH-1:0] dat;
    logic [ADDRESSWIDTH-1:0] pc;
  } entry_t;

  logic [ADDRESSWIDTH-1:0] r_pc;
  logic [ADDRESSWIDTH-1:0] r_inflight_pc;
  logic [1:0]              r_count;
  logic                    r_inflight;
  logic                    r_discard;
  entry_t                  r_buf0;
  entry_t                  r_buf1;

  logic       w_pop;
  logic       w_accept;
  logic       w_redir;
  logic       w_resp;
  logic       w_push;
  logic [2:0] w_occ_after_pop;
  logic [2:0] w_occ;
  logic [1:0] w_wr_idx;

  assign instr_valid = (r_count != 2'd0);
  assign instr       = r_buf0.dat;
  assign instr_pc    = r_buf0.pc;
  assign icache_addr = r_pc;

  assign w_pop           = instr_valid && instr_ready;
  // The in-flight slot counts as occupied buffer space, so a push can never overflow.
  assign w_occ_after_pop = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign icache_req      = !sync_rst && !redirect_valid && (w_occ_after_pop < 3'd2);

  assign w_accept = icache_req && !icache_busy && clk_en;
  assign w_redir  = redirect_valid && clk_en;
  assign w_resp   = r_inflight && !icache_busy && clk_en;
  assign w_push   = w_resp && !r_discard && !w_redir;
  assign w_wr_idx = r_count - {1'b0, w_pop};
  assign w_occ    = {1'b0, r_count} + {2'b00, r_inflight};

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      r_pc          <= RESET_VECTOR;
      r_inflight_pc <= RESET_VECTOR;
      r_count       <= 2'd0;
      r_inflight    <= 1'b0;
      r_discard     <= 1'b0;
    end else if (clk_en) begin
      if (w_redir) begin
        r_pc    <= redirect_addr;
        r_count <= 2'd0;
      end else begin
        if (w_accept) r_pc <= r_pc + ADDRESSWIDTH'(1);
        r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      end
      if (w_accept) r_inflight_pc <= r_pc;
      r_inflight <= w_accept || (r_inflight && !w_resp);
      // A redirect orphans any still-pending response; swallow it when it finally lands.
      if (w_resp) begin
        r_discard <= 1'b0;
      end else if (w_redir && r_inflight) begin
        r_discard <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clk_en && !sync_rst && !w_redir) begin
      if (w_pop) r_buf0 <= r_buf1;
      if (w_push) begin
        if (w_wr_idx == 2'd0) begin
          r_buf0 <= '{dat: icache_data, pc: r_inflight_pc};
        end else begin
          r_buf1 <= '{dat: icache_data, pc: r_inflight_pc};
        end
      end
    end
  end

  a_occupancy: assert property (@(posedge clk) disable iff (sync_rst) w_occ <= 3'd2);

endmodule
